// File: rtl/lvds_tx_framer.sv
// I/Q DDR serialiser for the AT86RF215 LVDS TX bus: frames FIFO samples with sync bits, 2 bits per clock.
// Optional internal ramp test pattern source: define LVDS_TX_FRAMER_TESTPAT_EN.
//
// state | meaning
// IDLE  | disabled, zero frames
// SYNC  | zero frames until SYNC_FRAMES frames seen with FIFO non-empty
// RUN   | sample frames, gap zero frames, underrun handling
// DRAIN | one zero frame after disable, then IDLE
module lvds_tx_framer #(
  parameter int SAMPLE_W    = 13,
  parameter int SYNC_FRAMES = 10,
  parameter int GAP_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic                  i_ddr_clk,
  input  logic                  i_rst_b,
  input  logic                  i_tx_en,
  input  logic                  i_fifo_empty,
  input  logic [2*SAMPLE_W-1:0] i_fifo_data,
  output logic                  o_fifo_pull,
  input  logic [GAP_W-1:0]      i_sample_gap,
  input  logic                  i_underrun_mode,
  input  logic                  i_ctrl_bit,
`ifdef LVDS_TX_FRAMER_TESTPAT_EN
  input  logic                  i_testpat,
`endif
  output logic [1:0]            o_ddr_data,
  output logic                  o_frame_strobe,
  output logic [1:0]            o_state,
  output logic [CNT_W-1:0]      o_underrun_count,
  output logic [CNT_W-1:0]      o_frame_count
);

  localparam int FRAME_W = 2 * (SAMPLE_W + 3);
  localparam int BEATS   = FRAME_W / 2;
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int SYNC_W  = $clog2(SYNC_FRAMES + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [SYNC_W-1:0] SYNC_INIT = SYNC_W'(SYNC_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [FRAME_W-1:0]    shift_q, load_d;
  logic [1:0]            ddr_q;
  logic [SYNC_W-1:0]     sync_q, sync_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [2*SAMPLE_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]      urun_q, urun_d;
  logic [CNT_W-1:0]      fcnt_q, fcnt_d;
  logic                  boundary;
  logic                  run_load;
  logic                  pull_d;
  logic                  sync_empty;
`ifdef LVDS_TX_FRAMER_TESTPAT_EN
  logic [SAMPLE_W-1:0]   ramp_q, ramp_d;
`endif

  function automatic logic [FRAME_W-1:0] mk_frame(input logic [2*SAMPLE_W-1:0] s, input logic ctrl);
    return {2'b10, s[2*SAMPLE_W-1:SAMPLE_W], ctrl, 2'b01, s[SAMPLE_W-1:0], 1'b0};
  endfunction

  assign boundary = (beat_q == BEAT_LAST);
  assign beat_d   = boundary ? '0 : beat_q + BEAT_W'(1);

`ifdef LVDS_TX_FRAMER_TESTPAT_EN
  assign sync_empty = i_fifo_empty && !i_testpat;
`else
  assign sync_empty = i_fifo_empty;
`endif

  always_comb begin
    state_d  = state_q;
    sync_d   = sync_q;
    gap_d    = gap_q;
    last_d   = last_q;
    urun_d   = urun_q;
    fcnt_d   = fcnt_q;
    load_d   = '0;
    pull_d   = 1'b0;
    run_load = 1'b0;
`ifdef LVDS_TX_FRAMER_TESTPAT_EN
    ramp_d   = ramp_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (boundary && i_tx_en) begin
          state_d = ST_SYNC;
          sync_d  = SYNC_INIT;
          gap_d   = '0;
        end
      end
      ST_SYNC: begin
        // an empty FIFO restarts the sync count on any cycle, not just at a boundary
        if (boundary && !i_tx_en) begin
          state_d = ST_DRAIN;
        end else if (sync_empty) begin
          sync_d = SYNC_INIT;
        end else if (boundary) begin
          if (sync_q == '0) begin
            state_d  = ST_RUN;
            run_load = 1'b1;
          end else begin
            sync_d = sync_q - SYNC_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (boundary) begin
          if (!i_tx_en) state_d = ST_DRAIN;
          else          run_load = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (boundary) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (run_load) begin
      if (gap_q != '0) begin
        gap_d = gap_q - GAP_W'(1);
`ifdef LVDS_TX_FRAMER_TESTPAT_EN
      end else if (i_testpat) begin
        load_d = mk_frame({ramp_q, ~ramp_q}, i_ctrl_bit);
        last_d = {ramp_q, ~ramp_q};
        ramp_d = ramp_q + SAMPLE_W'(1);
        gap_d  = i_sample_gap;
        fcnt_d = fcnt_q + CNT_W'(1);
`endif
      end else if (!i_fifo_empty) begin
        load_d = mk_frame(i_fifo_data, i_ctrl_bit);
        pull_d = 1'b1;
        last_d = i_fifo_data;
        gap_d  = i_sample_gap;
        fcnt_d = fcnt_q + CNT_W'(1);
      end else begin
        if (urun_q != '1) urun_d = urun_q + CNT_W'(1);
        if (i_underrun_mode) begin
          load_d = mk_frame(last_q, i_ctrl_bit);
          gap_d  = i_sample_gap;
        end else begin
          state_d = ST_SYNC;
          sync_d  = SYNC_INIT;
        end
      end
    end
  end

  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      shift_q <= '0;
      ddr_q   <= '0;
      sync_q  <= '0;
      gap_q   <= '0;
      last_q  <= '0;
      urun_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ddr_q   <= shift_q[FRAME_W-1 -: 2];
      shift_q <= boundary ? load_d : {shift_q[FRAME_W-3:0], 2'b00};
      sync_q  <= sync_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      urun_q  <= urun_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef LVDS_TX_FRAMER_TESTPAT_EN
  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) ramp_q <= '0;
    else          ramp_q <= ramp_d;
  end
`endif

  assign o_fifo_pull      = pull_d;
  assign o_frame_strobe   = boundary;
  assign o_ddr_data       = ddr_q;
  assign o_state          = state_q;
  assign o_underrun_count = urun_q;
  assign o_frame_count    = fcnt_q;

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Directed bench for lvds_tx_framer: sync, gaps, underrun modes, disable/drain and async reset.
module tb_lvds_tx_framer;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        tx_en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [25:0] fifo_data = '0;
  logic [3:0]  gap = '0;
  logic        mode = 1'b0;
  logic        ctrl = 1'b0;

  logic        pull, strobe;
  logic [1:0]  ddr, state;
  logic [15:0] ucnt, fcnt;
  logic        s_pull, s_strobe;
  logic [1:0]  s_ddr, s_state, s_ucnt, s_fcnt;

  lvds_tx_framer dut (
    .i_ddr_clk(clk), .i_rst_b(rst_b), .i_tx_en(tx_en), .i_fifo_empty(fifo_empty),
    .i_fifo_data(fifo_data), .o_fifo_pull(pull), .i_sample_gap(gap),
    .i_underrun_mode(mode), .i_ctrl_bit(ctrl), .o_ddr_data(ddr), .o_frame_strobe(strobe),
    .o_state(state), .o_underrun_count(ucnt), .o_frame_count(fcnt)
  );

  // narrow counters so saturation and wrap are reachable in a short run
  lvds_tx_framer #(.CNT_W(2)) dut_s (
    .i_ddr_clk(clk), .i_rst_b(rst_b), .i_tx_en(tx_en), .i_fifo_empty(fifo_empty),
    .i_fifo_data(fifo_data), .o_fifo_pull(s_pull), .i_sample_gap(gap),
    .i_underrun_mode(mode), .i_ctrl_bit(ctrl), .o_ddr_data(s_ddr), .o_frame_strobe(s_strobe),
    .o_state(s_state), .o_underrun_count(s_ucnt), .o_frame_count(s_fcnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, pulls = 0, cyc = 0;
  bit hold_empty = 1'b0;
  bit pre_strobe, pre_pull;
  int pull_cyc[16];
  logic [25:0] q[$];

  localparam logic [25:0] S1 = {13'h0ABC, 13'h1555};
  localparam logic [25:0] S2 = {13'h1234, 13'h0F0F};
  localparam logic [25:0] SA = {13'h0001, 13'h1FFE};
  localparam logic [25:0] SB = {13'h1FFF, 13'h0000};
  localparam logic [25:0] SC = {13'h0AAA, 13'h1555};
  localparam logic [25:0] SD = {13'h1001, 13'h0810};
  localparam logic [25:0] SX = {13'h1F00, 13'h00F1};

  function automatic logic [31:0] mkframe(input logic [25:0] s, input logic c);
    return {2'b10, s[25:13], c, 2'b01, s[12:0], 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fifo_upd();
    fifo_empty = (q.size() == 0) || hold_empty;
    fifo_data  = (q.size() > 0) ? q[0] : '0;
  endtask

  // one clock: sample combinational strobes before the edge, pop the model FIFO after it
  task automatic tick();
    #1;
    pre_strobe = strobe;
    pre_pull   = pull;
    if (pre_pull) chk("pull_while_empty", {31'b0, fifo_empty}, 32'd0);
    @(posedge clk);
    #1;
    cyc++;
    if (pre_pull) begin
      if (pulls < 16) pull_cyc[pulls] = cyc;
      pulls++;
      if (q.size() > 0) q.delete(0);
    end
    fifo_upd();
  endtask

  task automatic to_bnd(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pre_strobe && n < 40);
    if (!pre_strobe) begin
      checks++;
      errors++;
      $error("FAIL bnd_timeout: observed no strobe in %0d cycles expected strobe", n);
    end
  endtask

  task automatic grab(output logic [31:0] f);
    f = '0;
    repeat (16) begin
      tick();
      f = {f[29:0], ddr};
    end
  endtask

  initial begin
    logic [31:0] f, zacc, exp_f;
    int n, nb;
    logic [25:0] smp[4];
    smp[0] = SA; smp[1] = SB; smp[2] = SC; smp[3] = SD;

    // reset state
    q.push_back(S1);
    fifo_upd();
    tx_en = 1'b1;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_ddr", ddr, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_pull", pull, 0);
    chk("rst_ucnt", ucnt, 0);
    chk("rst_fcnt", fcnt, 0);
    rst_b = 1'b1;
    to_bnd(n);
    chk("first_bnd_cycles", n, 16);
    chk("idle_to_sync", state, 1);

    // test 1: ten sync zero frames then the sample frame
    zacc = '0;
    nb = 0;
    do begin
      grab(f);
      zacc |= f;
      nb++;
    end while (state != 2 && nb < 20);
    chk("sync_frames_to_run", nb, 11);
    chk("sync_frames_zero", zacc, 0);
    chk("pull_at_first_load", pulls, 1);
    chk("fcnt_after_s1", fcnt, 1);

    // test 4a: empty FIFO in mode 0 -> zero frame, back to SYNC
    grab(f);
    chk("s1_frame", f, 32'h9578_6AAA);
    chk("urun0_state", state, 1);
    chk("urun0_count", ucnt, 1);
    chk("urun0_count_small", s_ucnt, 1);

    // test 2: FIFO stays empty in SYNC, then refills with a mid-frame empty blip
    repeat (3) to_bnd(n);
    chk("empty_sync_state", state, 1);
    chk("empty_sync_nopull", pulls, 1);
    ctrl = 1'b1;
    q.push_back(S2);
    fifo_upd();
    repeat (5) to_bnd(n);
    chk("sync_counting_state", state, 1);
    hold_empty = 1'b1;
    fifo_upd();
    repeat (3) tick();
    hold_empty = 1'b0;
    fifo_upd();
    nb = 0;
    do begin
      to_bnd(n);
      nb++;
    end while (state != 2 && nb < 20);
    chk("resync_bnds_to_run", nb, 11);
    chk("resync_pulls", pulls, 2);

    // test 3: gap of 3 zero frames after each of four samples
    gap = 4'd3;
    mode = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(smp[i]);
    fifo_upd();
    grab(f);
    chk("s2_frame_ctrl1", f, mkframe(S2, 1'b1));
    for (int j = 0; j < 16; j++) begin
      grab(f);
      exp_f = (j % 4 == 0) ? mkframe(smp[j/4], 1'b1) : 32'd0;
      chk($sformatf("gap_frame_%0d", j), f, exp_f);
    end
    chk("gap_pulls", pulls, 6);
    chk("gap_fcnt", fcnt, 6);
    chk("gap_fcnt_wrap_small", s_fcnt, 2);
    for (int k = 3; k < 6; k++)
      chk($sformatf("pull_spacing_%0d", k), pull_cyc[k] - pull_cyc[k-1], 64);

    // test 4b: mode 1 underrun repeats last sample, stays in RUN
    chk("urun1_state", state, 2);
    chk("urun1_count", ucnt, 2);
    gap = 4'd0;
    grab(f);
    chk("urun1_repeat_frame", f, mkframe(SD, 1'b1));
    chk("urun1_nopull", pulls, 6);
    repeat (4) to_bnd(n);
    chk("urun_count_4", ucnt, 4);
    chk("urun_sat_small", s_ucnt, 3);
    chk("urun_run_state", state, 2);

    // test 5: disable mid-frame, current frame completes, one DRAIN frame, then IDLE
    q.push_back(SX);
    fifo_upd();
    f = '0;
    for (int k = 0; k < 16; k++) begin
      tick();
      f = {f[29:0], ddr};
      if (k == 4) tx_en = 1'b0;
    end
    chk("drop_frame_completes", f, mkframe(SD, 1'b1));
    chk("drain_state", state, 3);
    grab(f);
    chk("drain_frame_zero", f, 0);
    chk("drain_to_idle", state, 0);
    to_bnd(n);
    chk("idle_holds", state, 0);
    chk("no_pull_after_disable", pulls, 6);

    // test 6: restart, then async reset mid-frame
    tx_en = 1'b1;
    nb = 0;
    do begin
      to_bnd(n);
      nb++;
    end while (state != 2 && nb < 20);
    chk("restart_bnds_to_run", nb, 12);
    chk("restart_pull", pulls, 7);
    tick();
    chk("x_first_pair", ddr, 2'b10);
    rst_b = 1'b0;
    #1;
    chk("async_rst_ddr", ddr, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_fcnt", fcnt, 0);
    chk("async_rst_ucnt", ucnt, 0);
    tick(); tick();
    rst_b = 1'b1;
    to_bnd(n);
    chk("post_rst_bnd_cycles", n, 16);
    chk("post_rst_sync", state, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lvds_tx_framer.md
Name: lvds_tx_framer

Overview:
- Parametrised next-generation I/Q DDR serialiser for the AT86RF215 LVDS TX bus, running entirely in the i_ddr_clk domain.
- Pulls one complete I/Q sample per frame from a show-ahead TX FIFO and frames it with I/Q sync bits.
- Emits frames MSB-first, 2 bits per clock.
- Adds parametrised sample width and sync length, per-sample gap insertion, selectable underrun policy, underrun/frame statistics, and clean enable/disable. Sits between the TX FIFO and the LVDS output pads.

Parameters:
SAMPLE_W, 13, bits per I and per Q sample; FRAME_W = 2*(SAMPLE_W+3) (32 at default)
SYNC_FRAMES, 10, zero frames sent with FIFO non-empty before streaming starts
GAP_W, 4, width of i_sample_gap
CNT_W, 16, width of statistics counters

Ports:
i_ddr_clk  in  1  serial bit clock; all logic on posedge
i_rst_b  in  1  asynchronous active-low reset
i_tx_en  in  1  stream enable
i_fifo_empty  in  1  FIFO empty flag
i_fifo_data  in  2*SAMPLE_W  show-ahead head word: {I, Q}; valid while !i_fifo_empty
o_fifo_pull  out  1  one-cycle pop strobe
i_sample_gap  in  GAP_W  zero frames inserted after each sample frame
i_underrun_mode  in  1  0 = zero frame and resync; 1 = repeat last sample frame
i_ctrl_bit  in  1  value placed in the frame control bit
o_ddr_data  out  2  serial pair {earlier bit, later bit}
o_frame_strobe  out  1  high for one cycle on each frame load
o_state  out  2  0 IDLE, 1 SYNC, 2 RUN, 3 DRAIN
o_underrun_count  out  CNT_W  saturating underrun counter
o_frame_count  out  CNT_W  wrapping counter of sample frames sent

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE.
  - Shift register 0.
  - Beat counter 0.
  - Last-sample register 0.
- Frame format, MSB first: {2'b10, I[SAMPLE_W-1:0], i_ctrl_bit, 2'b01, Q[SAMPLE_W-1:0], 1'b0}. A zero frame is all zeros.
- Beat counter:
  - Runs 0..FRAME_W/2-1 continuously out of reset and wraps.
  - Boundary = the cycle where the count equals FRAME_W/2-1.
  - On a boundary cycle the shift register loads the next frame and o_frame_strobe=1.
  - On every other cycle the shift register shifts left by 2.
- Output: o_ddr_data is registered from the top two shift bits. The first bit pair of a loaded frame appears 1 cycle after the load.
- Decisions (state change, pop, counters) are taken only on boundary cycles. One exception: SYNC counter reload on FIFO empty happens on any cycle.
- IDLE:
  - Loads zero frames.
  - If i_tx_en=1: SYNC counter = SYNC_FRAMES, go to SYNC.
- SYNC:
  - Loads zero frames.
  - Whenever i_fifo_empty=1, the counter reloads to SYNC_FRAMES.
  - Otherwise it decrements at each boundary.
  - If the counter is 0 at a boundary, go to RUN and perform a RUN load in the same boundary.
- RUN, each boundary:
  - If gap counter > 0: load a zero frame, decrement the gap counter.
  - Else if FIFO non-empty:
    - Load the sample frame and pulse o_fifo_pull for exactly this cycle.
    - Latch the sample into the last-sample register.
    - Set gap counter = i_sample_gap.
    - o_frame_count++.
  - Else (underrun):
    - o_underrun_count++, saturating at all-ones.
    - Mode 0: load a zero frame, counter = SYNC_FRAMES, go to SYNC.
    - Mode 1: reload the last sample frame, no pull, stay in RUN, set gap counter = i_sample_gap.
- i_tx_en=0 while in SYNC or RUN: at the next boundary go to DRAIN and load a zero frame.
- DRAIN: stays one full zero frame, then goes to IDLE, and re-enters SYNC if i_tx_en is high again. No pops occur in DRAIN.
- o_fifo_pull is never asserted when i_fifo_empty=1 and is never asserted more than once per frame.
- Reset asserted mid-frame: outputs go to 0 immediately (async). The bus restarts from IDLE with the beat counter at 0.
- Counters wrap (frame) or saturate (underrun) without affecting the datapath.

Optional Feature:
- Macro: LVDS_TX_FRAMER_TESTPAT_EN.
- When defined:
  - Adds input i_testpat (1 bit).
  - With i_testpat=1 in RUN, sample frames use an internal SAMPLE_W ramp: I=ramp, Q=~ramp, ramp++ per sample frame, ramp reset value 0.
  - The FIFO is ignored: no pulls, no underruns.
  - SYNC still requires SYNC_FRAMES frames but ignores i_fifo_empty.
- When undefined: the port and logic are absent, and the FIFO is the only sample source.

Test Plan:
1. Reset, then i_tx_en=1 with FIFO non-empty holding {I=13'h0ABC, Q=13'h1555}, gap=0, ctrl=0 -> exactly 10 zero frames, then o_ddr_data serialises 32'hABC_0 pattern {10,0ABC,0,01,1555,0}. o_fifo_pull is one cycle at that load. o_state=2.
2. FIFO empty for 3 frames during SYNC, then non-empty -> SYNC counter restarts; streaming starts 10 frames after the FIFO goes non-empty; no pull while empty.
3. gap=3 with 4 queued samples -> each sample frame is followed by 3 zero frames. 4 pulls spaced 4 frames (64 cycles) apart. o_frame_count=4.
4. Underrun in mode 0 versus mode 1 -> mode 0: zero frame, o_state=1, count=1. Mode 1: previous sample frame repeated, no pull, o_state=2, count=1. Saturation checked with a forced count of 16'hFFFF.
5. i_tx_en dropped mid-frame -> the current frame completes, then DRAIN (o_state=3) for 1 zero frame, then IDLE. No pull after deassertion.
6. Async reset asserted mid-frame -> o_ddr_data=0 in the same cycle. After release, the first frame boundary occurs 16 cycles later.
